// File: rtl/xosera_pkg.sv
// Shared primitive-renderer definitions: command word layout and opcodes.
package xv;

  localparam logic [3:0] PRIM_CMD_START = 4'hF;

  typedef enum logic [3:0] {
    PRIM_X0    = 4'h0,
    PRIM_Y0    = 4'h1,
    PRIM_X1    = 4'h2,
    PRIM_Y1    = 4'h3,
    PRIM_COLOR = 4'h4,
    PRIM_START = 4'hF
  } prim_op_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [11:0] operand;
  } prim_cmd_t;

endpackage

// File: rtl/sync_fifo.sv
// Parameterised synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LW-1:0]    wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic             do_push, do_pop;

  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign wr_nxt  = wr_ptr + LW'(do_push);
  assign rd_nxt  = rd_ptr + LW'(do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      level  <= wr_nxt - rd_nxt;
      full   <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
      empty  <= (wr_nxt == rd_nxt);
    end
  end

endmodule

// File: rtl/prim_cmd_queue.sv
// Command queue ahead of the primitive renderer; holds issue after a start
// command until the renderer reports line completion.
module prim_cmd_queue
  import xv::*;
#(
  parameter  int DEPTH = 16,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n_i,
  input  logic          wr_i,
  input  logic [15:0]   wr_data_i,
  input  logic          clear_i,
  input  logic          done_i,
  output logic [15:0]   cmd_o,
  output logic          cmd_valid_o,
  output logic          full_o,
  output logic [LW-1:0] level_o,
  output logic          busy_o,
  output logic          overflow_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t        state, state_nxt;
  logic          pop, push_ok, busy_nxt, empty, full;
  logic [15:0]   head;
  logic [LW-1:0] level;
  prim_cmd_t     head_cmd;

  assign head_cmd = head;
  assign full_o   = full;
  assign level_o  = level;

  sync_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset_n_i),
    .clear (clear_i),
    .push  (wr_i),
    .pop   (pop),
    .wdata (wr_data_i),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge reset_n_i)
    if (!reset_n_i) state <= IDLE;
    else            state <= state_nxt;

  // IDLE pops directly so a word pushed into an empty queue issues two edges later.
  always_comb begin
    state_nxt = IDLE;
    pop       = 1'b0;
    push_ok   = wr_i && !full;
    busy_nxt  = 1'b0;
    case (state)
      IDLE, ISSUE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_cmd.op == PRIM_CMD_START)   state_nxt = WAIT_DONE;
          else if (level != LW'(1) || push_ok) state_nxt = ISSUE;
        end
      end
      WAIT_DONE: begin
        if (!done_i)                state_nxt = WAIT_DONE;
        else if (!empty || push_ok) state_nxt = ISSUE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE) || (level != LW'(pop)) || push_ok;
    if (clear_i) begin
      state_nxt = IDLE;
      pop       = 1'b0;
      busy_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cmd_o       <= '0;
      cmd_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      cmd_valid_o <= pop;
      busy_o      <= busy_nxt;
      if (pop) cmd_o <= head;
      if (clear_i)          overflow_o <= 1'b0;
      else if (wr_i && full) overflow_o <= 1'b1;
    end
  end

endmodule

// File: doc/prim_cmd_queue.md
# prim_cmd_queue

Command queue that sits directly upstream of the primitive renderer. It buffers 16-bit primitive command words written by the register interface and issues them to the renderer's `cmd_i`/`cmd_valid_i` inputs at most one per cycle. It stalls issue after a start command (opcode `4'hF`) until the renderer reports line completion, so the next primitive's coordinates never overwrite the ones in use mid-draw.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, 4..256
- `clk`  in  1  system clock
- `reset_n_i`  in  1  asynchronous, active-low reset
- `wr_i`  in  1  push strobe from register interface, one word per cycle
- `wr_data_i`  in  16  command word: [15:12] opcode, [11:0] operand
- `clear_i`  in  1  synchronous flush of queue, state and overflow flag
- `done_i`  in  1  renderer line-complete pulse, high for one cycle
- `cmd_o`  out  16  command word to renderer
- `cmd_valid_o`  out  1  one-cycle qualifier for `cmd_o`
- `full_o`  out  1  queue holds `DEPTH` entries
- `level_o`  out  $clog2(DEPTH)+1  current entry count
- `busy_o`  out  1  queue non-empty or state not IDLE
- `overflow_o`  out  1  sticky: a push was dropped

## Operation
- FIFO with read/write pointers of $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty. Pointers wrap modulo 2·DEPTH.
- Push: accepted when `wr_i` is high and `full_o` is low. Push while full drops the word and sets `overflow_o`. A pop in the same cycle does not rescue a push into a full queue.
- States:
  - IDLE: queue empty; `cmd_valid_o` low. Moves to ISSUE when `level_o` is non-zero.
  - ISSUE: each cycle with a non-empty queue, pops the head into `cmd_o` and pulses `cmd_valid_o`.
    - Popped opcode == `PRIM_CMD_START`: go to WAIT_DONE.
    - Queue becomes empty: go to IDLE.
  - WAIT_DONE: no pops. `done_i` high moves to ISSUE if the queue is non-empty, otherwise to IDLE.
- `done_i` outside WAIT_DONE is ignored.
- `clear_i`: resets pointers, returns to IDLE, clears `overflow_o` and `cmd_valid_o` on the next edge. It has priority over a simultaneous `wr_i` (word dropped, no overflow flagged) and over `done_i`. Clearing in WAIT_DONE does not abort a line already drawing in the renderer.
- Opcodes other than `4'hF` pass through unchanged and never stall.

## Timing
- Reset values: `cmd_o` = 0, `cmd_valid_o` = 0, `full_o` = 0, `level_o` = 0, `busy_o` = 0, `overflow_o` = 0; state IDLE; pointers 0.
- All outputs are registered.
- Latency: word pushed at edge E0 appears on `cmd_o` with `cmd_valid_o` high in the cycle after edge E1 (2 edges, empty queue, IDLE).
- Throughput: back-to-back non-start commands issue on consecutive cycles.
- After a start command issues at edge Es, the next command issues no earlier than the edge following the edge that samples `done_i`.
- `level_o` and `full_o` reflect all pushes and pops of the preceding edge. Simultaneous push and pop leave `level_o` unchanged.
- Reset asserted mid-operation clears everything immediately, without waiting for `clk`.

## Structure
- Add `PRIM_CMD_START` (4'hF) and the opcode enum (X0, Y0, X1, Y1, COLOR, START) to `xosera_pkg` under `xv::`, shared with the renderer.
- State enum is local to the module.
- One sub-module, `sync_fifo`: a parameterised width/depth synchronous FIFO with storage, pointers, `level`, `full` and `empty`. It is reused for future command sources.
- The FSM and overflow flag stay in `prim_cmd_queue`.

## Test plan
- Reset, then push 0x0010, 0x1020, 0x2030 on consecutive cycles -> `cmd_valid_o` pulses on 3 consecutive cycles with the same words in order, first 2 edges after the first push; `level_o` returns to 0, `busy_o` falls.
- Push 0x0005, 0xF000, 0x1007 -> 0x0005 and 0xF000 issue. 0x1007 is held (`level_o` = 1) until `done_i` is pulsed 20 cycles later, then issues on the next edge.
- With DEPTH=16 held in WAIT_DONE, push 17 words -> `full_o` high after 16, 17th dropped, `overflow_o` = 1, `level_o` = 16.
- Push while full with `done_i` pulsed the same cycle -> word still dropped; `overflow_o` set.
- In WAIT_DONE with 5 queued, assert `clear_i` together with `wr_i` -> next cycle `level_o` = 0, IDLE, `overflow_o` = 0, no `cmd_valid_o`. A subsequent `done_i` is ignored.
- Deassert `reset_n_i` between clock edges mid-ISSUE -> all outputs read 0 immediately; after release, a single push issues with 2-edge latency.
